// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART command bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        BUS   = 2'd2,
        RESP  = 2'd3
    } bridge_st_e;

    localparam logic [7:0] BrgAck = 8'h06;
    localparam logic [7:0] BrgNak = 8'h15;

    // Command byte layout: bit 7 selects write, the low bits carry the word address.
    localparam int CmdWeBit   = 7;
    localparam int CmdAddrMsb = 6;

endpackage

// File: rtl/uart_reg_bridge.sv
// Decodes read/write commands from a UART byte stream, runs one register bus
// transaction per command and returns ACK/NAK or read data LSB first.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int                  AW            = 7,
    parameter int                  DW            = 32,
    parameter int                  TimeoutW      = 16,
    parameter logic [TimeoutW-1:0] TimeoutCycles = 16'hFFFF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_frame_err_i,
    output logic          tx_valid_o,
    output logic [7:0]    tx_data_o,
    input  logic          tx_ready_i,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW+1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_ack_i,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_err_i,
    output logic          busy_o,
    output logic          overrun_o,
    output logic          abort_o,
    output bridge_st_e    state_o
);

    localparam int            NumBytes = DW / 8;
    localparam int            IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    bridge_st_e          state;
    logic [IdxW-1:0]     byte_idx;
    logic [TimeoutW-1:0] tmo_cnt;
    logic [DW-1:0]       resp_sh;
    logic                resp_single;

    logic rx_ok;
    logic timeout_hit;
    logic frame_abort;

    // Handshakes: rx is a one-cycle valid pulse with no backpressure; tx moves a
    // byte when tx_valid_o & tx_ready_i; bus_req_o holds until the bus_ack_i cycle.
    assign rx_ok       = rx_valid_i & ~rx_frame_err_i;
    assign timeout_hit = (TimeoutCycles != '0) && (state == WDATA) && !rx_valid_i &&
                         (tmo_cnt == TimeoutCycles - 1'b1);
    assign frame_abort = rx_valid_i & rx_frame_err_i & ((state == IDLE) | (state == WDATA));

    assign abort_o   = timeout_hit | frame_abort;
    assign overrun_o = rx_valid_i & ((state == BUS) | (state == RESP));
    assign busy_o    = (state != IDLE);
    assign state_o   = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            byte_idx    <= '0;
            tmo_cnt     <= '0;
            resp_sh     <= '0;
            resp_single <= 1'b0;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_ok) begin
                        bus_we_o   <= rx_data_i[CmdWeBit];
                        bus_addr_o <= {rx_data_i[CmdAddrMsb -: AW], 2'b00};
                        byte_idx   <= '0;
                        tmo_cnt    <= '0;
                        if (rx_data_i[CmdWeBit]) begin
                            state <= WDATA;
                        end else begin
                            state     <= BUS;
                            bus_req_o <= 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (rx_valid_i) begin
                        tmo_cnt <= '0;
                        if (rx_frame_err_i) begin
                            state <= IDLE;
                        end else begin
                            bus_wdata_o[8*byte_idx +: 8] <= rx_data_i;
                            if (byte_idx == LastIdx) begin
                                byte_idx  <= '0;
                                state     <= BUS;
                                bus_req_o <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end
                    end else if (timeout_hit) begin
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                BUS: begin
                    if (bus_ack_i) begin
                        bus_req_o   <= 1'b0;
                        state       <= RESP;
                        tx_valid_o  <= 1'b1;
                        byte_idx    <= '0;
                        resp_single <= bus_err_i | bus_we_o;
                        resp_sh     <= bus_rdata_i >> 8;
                        if (bus_err_i) begin
                            tx_data_o <= BrgNak;
                        end else if (bus_we_o) begin
                            tx_data_o <= BrgAck;
                        end else begin
                            tx_data_o <= bus_rdata_i[7:0];
                        end
                    end
                end

                RESP: begin
                    if (tx_ready_i) begin
                        if (resp_single || (byte_idx == LastIdx)) begin
                            state      <= IDLE;
                            tx_valid_o <= 1'b0;
                            byte_idx   <= '0;
                        end else begin
                            tx_data_o <= resp_sh[7:0];
                            resp_sh   <= resp_sh >> 8;
                            byte_idx  <= byte_idx + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
